clk_step_ctrl: RTL and testbench

- Run/stop/single-step controller for the processor clock resource.
- Converts the board clock into a CPU clock-enable pulse train with a programmable period.
- Supports a single-step handshake from debug buttons and halts on request from the CPU.
- Also produces a slow toggled clock, one edge per CPU tick, for LED/display use.

---
 rtl/clk_step_ctrl.sv | 141 ++++++++++++++
 tb/tb_clk_step_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_step_ctrl.sv
// Run/stop/single-step controller: turns the board clock into a CPU clock-enable pulse train.
// Optional PC breakpoint halting is compiled in with `define CLK_STEP_BREAKPOINT_EN.
module clk_step_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3,
  parameter int TCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stop,
  input  logic              step,
  input  logic              halt_in,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_in,
`ifdef CLK_STEP_BREAKPOINT_EN
  input  logic [7:0]        pc,
  input  logic [7:0]        bp_addr,
  input  logic              bp_en,
  output logic              bp_hit,
`endif
  output logic              cpu_en,
  output logic              step_done,
  output logic              clk_slow,
  output logic [1:0]        state,
  output logic [TCNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;

  // Control pulses (run/stop/step) are single-cycle requests sampled on every
  // edge; there is no back-pressure, a request is either acted on or dropped.
  logic run_due;
  logic bp_block;
  logic tick_run;
  logic tick_step;
  logic tick;

`ifdef CLK_STEP_BREAKPOINT_EN
  logic bp_skip;
`endif

  assign state = state_q;

  always_comb begin
    run_due   = (state_q == ST_RUN) && !halt_in && !stop && !div_load && (cnt == div_reg);
    bp_block  = 1'b0;
`ifdef CLK_STEP_BREAKPOINT_EN
    bp_block  = bp_en && (pc == bp_addr) && !bp_skip;
`endif
    tick_run  = run_due && !bp_block;
    tick_step = (state_q == ST_STEP) && !halt_in;
    tick      = tick_run || tick_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOP;
      div_reg    <= DIV_W'(DEFAULT_DIV);
      cnt        <= '0;
      cpu_en     <= 1'b0;
      step_done  <= 1'b0;
      clk_slow   <= 1'b0;
      tick_count <= '0;
`ifdef CLK_STEP_BREAKPOINT_EN
      bp_hit     <= 1'b0;
      bp_skip    <= 1'b0;
`endif
    end else begin
      cpu_en    <= tick;
      step_done <= tick_step;
      if (tick) begin
        clk_slow   <= ~clk_slow;
        tick_count <= tick_count + 1'b1;
      end

      case (state_q)
        ST_STOP: begin
          cnt <= '0;
          if (halt_in)   state_q <= ST_HALTED;
          else if (step) state_q <= ST_STEP;
          else if (run)  state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_in) begin
            state_q <= ST_HALTED;
            cnt     <= '0;
          end else if (stop) begin
            state_q <= ST_STOP;
            cnt     <= '0;
          end else if (run_due) begin
            cnt <= '0;
            if (bp_block) begin
              state_q <= ST_HALTED;
`ifdef CLK_STEP_BREAKPOINT_EN
              bp_hit  <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
`ifdef CLK_STEP_BREAKPOINT_EN
          if (tick_run) bp_skip <= 1'b0;
`endif
        end
        ST_STEP: begin
          cnt     <= '0;
          state_q <= halt_in ? ST_HALTED : ST_STOP;
        end
        ST_HALTED: begin
          cnt <= '0;
          if (run && !halt_in) begin
            state_q <= ST_RUN;
`ifdef CLK_STEP_BREAKPOINT_EN
            // Resuming from a breakpoint lets the next tick through unchecked.
            bp_hit  <= 1'b0;
            bp_skip <= bp_hit;
`endif
          end
        end
        default: state_q <= ST_STOP;
      endcase

      // A divisor load restarts the period from zero and overrides the count update.
      if (div_load) begin
        div_reg <= div_in;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed testbench for clk_step_ctrl; expected values are hand-computed per vector.
// Breakpoint checks are included when CLK_STEP_BREAKPOINT_EN is defined.
module tb_clk_step_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        stop;
  logic        step;
  logic        halt_in;
  logic        div_load;
  logic [7:0]  div_in;
  logic        cpu_en;
  logic        step_done;
  logic        clk_slow;
  logic [1:0]  state;
  logic [15:0] tick_count;
`ifdef CLK_STEP_BREAKPOINT_EN
  logic [7:0]  pc;
  logic [7:0]  bp_addr;
  logic        bp_en;
  logic        bp_hit;
`endif

  int          vecs;
  int          errs;
  logic [15:0] exp_tcnt;
  logic        exp_en;

  clk_step_ctrl #(.DIV_W(8), .DEFAULT_DIV(3), .TCNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .stop(stop), .step(step),
    .halt_in(halt_in), .div_load(div_load), .div_in(div_in),
`ifdef CLK_STEP_BREAKPOINT_EN
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .bp_hit(bp_hit),
`endif
    .cpu_en(cpu_en), .step_done(step_done), .clk_slow(clk_slow),
    .state(state), .tick_count(tick_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle so registered outputs can be sampled.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    edge1();
    edge1();
    rst = 1'b0;
    exp_tcnt = 16'd0;
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL reset_state: got %b want 00", state); end
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
    vecs++; if (step_done !== 1'b0) begin errs++; $display("FAIL reset_step_done: got %b want 0", step_done); end
    vecs++; if (clk_slow !== 1'b0) begin errs++; $display("FAIL reset_clk_slow: got %b want 0", clk_slow); end
    vecs++; if (tick_count !== 16'd0) begin errs++; $display("FAIL reset_tick_count: got %0d want 0", tick_count); end
  endtask

  task automatic test_run_default();
    run = 1'b1;
    edge1();
    run = 1'b0;
    vecs++; if (state !== 2'b01) begin errs++; $display("FAIL run_enter_state: got %b want 01", state); end
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL run_enter_cpu_en: got %b want 0", cpu_en); end
    for (int i = 1; i <= 12; i++) begin
      edge1();
      exp_en = ((i % 4) == 0);
      if (exp_en) exp_tcnt = exp_tcnt + 16'd1;
      vecs++; if (cpu_en !== exp_en) begin errs++; $display("FAIL run_pulse edge %0d: got %b want %b", i, cpu_en, exp_en); end
      vecs++; if (clk_slow !== exp_tcnt[0]) begin errs++; $display("FAIL run_clk_slow edge %0d: got %b want %b", i, clk_slow, exp_tcnt[0]); end
    end
    vecs++; if (tick_count !== 16'd3) begin errs++; $display("FAIL run_tick_count: got %0d want 3", tick_count); end
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL run_stop_state: got %b want 00", state); end
    for (int i = 1; i <= 6; i++) begin
      edge1();
      vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL stopped_no_pulse edge %0d: got %b want 0", i, cpu_en); end
    end
  endtask

  task automatic test_divisor();
    div_load = 1'b1; div_in = 8'd0;
    edge1();
    div_load = 1'b0;
    run = 1'b1;
    edge1();
    run = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      edge1();
      vecs++; if (cpu_en !== 1'b1) begin errs++; $display("FAIL div0_pulse edge %0d: got %b want 1", i, cpu_en); end
    end
    vecs++; if (tick_count !== 16'd7) begin errs++; $display("FAIL div0_tick_count: got %0d want 7", tick_count); end
    div_load = 1'b1; div_in = 8'd9;
    edge1();
    div_load = 1'b0;
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL div_load_suppress: got %b want 0", cpu_en); end
    for (int i = 1; i <= 10; i++) begin
      edge1();
      exp_en = (i == 10);
      vecs++; if (cpu_en !== exp_en) begin errs++; $display("FAIL div9_pulse edge %0d: got %b want %b", i, cpu_en, exp_en); end
    end
    vecs++; if (tick_count !== 16'd8) begin errs++; $display("FAIL div9_tick_count: got %0d want 8", tick_count); end
    vecs++; if (clk_slow !== 1'b0) begin errs++; $display("FAIL div9_clk_slow: got %b want 0", clk_slow); end
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    div_load = 1'b1; div_in = 8'd3;
    edge1();
    div_load = 1'b0;
  endtask

  task automatic test_step();
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL step_pre_state: got %b want 00", state); end
    step = 1'b1;
    edge1();
    step = 1'b0;
    vecs++; if (state !== 2'b10) begin errs++; $display("FAIL step1_state: got %b want 10", state); end
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL step1_early_cpu_en: got %b want 0", cpu_en); end
    // run, stop and step while in STEP must all be ignored
    run = 1'b1; stop = 1'b1; step = 1'b1;
    edge1();
    run = 1'b0; stop = 1'b0; step = 1'b0;
    vecs++; if (cpu_en !== 1'b1) begin errs++; $display("FAIL step1_cpu_en: got %b want 1", cpu_en); end
    vecs++; if (step_done !== 1'b1) begin errs++; $display("FAIL step1_done: got %b want 1", step_done); end
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL step1_return_state: got %b want 00", state); end
    vecs++; if (tick_count !== 16'd9) begin errs++; $display("FAIL step1_tick_count: got %0d want 9", tick_count); end
    edge1();
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL step1_after_cpu_en: got %b want 0", cpu_en); end
    vecs++; if (step_done !== 1'b0) begin errs++; $display("FAIL step1_after_done: got %b want 0", step_done); end
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL step1_after_state: got %b want 00", state); end
    // stop together with step in STOP: step wins
    step = 1'b1; stop = 1'b1;
    edge1();
    step = 1'b0; stop = 1'b0;
    vecs++; if (state !== 2'b10) begin errs++; $display("FAIL step2_state: got %b want 10", state); end
    edge1();
    vecs++; if (cpu_en !== 1'b1) begin errs++; $display("FAIL step2_cpu_en: got %b want 1", cpu_en); end
    vecs++; if (step_done !== 1'b1) begin errs++; $display("FAIL step2_done: got %b want 1", step_done); end
    vecs++; if (tick_count !== 16'd10) begin errs++; $display("FAIL step2_tick_count: got %0d want 10", tick_count); end
    vecs++; if (clk_slow !== 1'b0) begin errs++; $display("FAIL step2_clk_slow: got %b want 0", clk_slow); end
    edge1();
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL step2_after_cpu_en: got %b want 0", cpu_en); end
  endtask

  task automatic test_halt();
    run = 1'b1;
    edge1();
    run = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      edge1();
      vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL halt_pre edge %0d: got %b want 0", i, cpu_en); end
    end
    halt_in = 1'b1;
    edge1();
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL halt_tick_suppressed: got %b want 0", cpu_en); end
    vecs++; if (state !== 2'b11) begin errs++; $display("FAIL halt_state: got %b want 11", state); end
    vecs++; if (tick_count !== 16'd10) begin errs++; $display("FAIL halt_tick_count: got %0d want 10", tick_count); end
    run = 1'b1;
    edge1();
    vecs++; if (state !== 2'b11) begin errs++; $display("FAIL halt_run_with_halt: got %b want 11", state); end
    halt_in = 1'b0;
    edge1();
    run = 1'b0;
    vecs++; if (state !== 2'b01) begin errs++; $display("FAIL halt_resume_state: got %b want 01", state); end
    for (int i = 1; i <= 4; i++) begin
      edge1();
      exp_en = (i == 4);
      vecs++; if (cpu_en !== exp_en) begin errs++; $display("FAIL halt_resume_pulse edge %0d: got %b want %b", i, cpu_en, exp_en); end
    end
    vecs++; if (tick_count !== 16'd11) begin errs++; $display("FAIL halt_resume_tick_count: got %0d want 11", tick_count); end
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    // halt during STEP cancels the step tick
    step = 1'b1;
    edge1();
    step = 1'b0;
    halt_in = 1'b1;
    edge1();
    halt_in = 1'b0;
    vecs++; if (state !== 2'b11) begin errs++; $display("FAIL step_halt_state: got %b want 11", state); end
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL step_halt_cpu_en: got %b want 0", cpu_en); end
    vecs++; if (step_done !== 1'b0) begin errs++; $display("FAIL step_halt_done: got %b want 0", step_done); end
    run = 1'b1;
    edge1();
    run = 1'b0;
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL step_halt_exit_state: got %b want 00", state); end
  endtask

  task automatic test_stop_rst();
    run = 1'b1;
    edge1();
    run = 1'b0;
    repeat (3) edge1();
    stop = 1'b1;
    edge1();
    stop = 1'b0;
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL stop_on_tick_cpu_en: got %b want 0", cpu_en); end
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL stop_on_tick_state: got %b want 00", state); end
    vecs++; if (tick_count !== 16'd11) begin errs++; $display("FAIL stop_on_tick_count: got %0d want 11", tick_count); end
    for (int i = 1; i <= 5; i++) begin
      edge1();
      vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL stop_quiet edge %0d: got %b want 0", i, cpu_en); end
    end
    // a divisor of 7 must be discarded by the reset below
    div_load = 1'b1; div_in = 8'd7;
    edge1();
    div_load = 1'b0;
    run = 1'b1;
    edge1();
    run = 1'b0;
    repeat (2) edge1();
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL rst_run_state: got %b want 00", state); end
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL rst_run_cpu_en: got %b want 0", cpu_en); end
    vecs++; if (tick_count !== 16'd0) begin errs++; $display("FAIL rst_run_tick_count: got %0d want 0", tick_count); end
    vecs++; if (clk_slow !== 1'b0) begin errs++; $display("FAIL rst_run_clk_slow: got %b want 0", clk_slow); end
    step = 1'b1;
    edge1();
    step = 1'b0;
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL rst_step_cpu_en: got %b want 0", cpu_en); end
    vecs++; if (step_done !== 1'b0) begin errs++; $display("FAIL rst_step_done: got %b want 0", step_done); end
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL rst_step_state: got %b want 00", state); end
    edge1();
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL rst_step_no_late_tick: got %b want 0", cpu_en); end
    vecs++; if (tick_count !== 16'd0) begin errs++; $display("FAIL rst_step_tick_count: got %0d want 0", tick_count); end
    // divisor back to its default of 3: first pulse after the 4th edge
    run = 1'b1;
    edge1();
    run = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      edge1();
      exp_en = (i == 4);
      vecs++; if (cpu_en !== exp_en) begin errs++; $display("FAIL rst_div_default edge %0d: got %b want %b", i, cpu_en, exp_en); end
    end
    stop = 1'b1;
    edge1();
    stop = 1'b0;
  endtask

`ifdef CLK_STEP_BREAKPOINT_EN
  task automatic test_breakpoint();
    bp_en = 1'b1; bp_addr = 8'h10; pc = 8'h10;
    run = 1'b1;
    edge1();
    run = 1'b0;
    vecs++; if (bp_hit !== 1'b0) begin errs++; $display("FAIL bp_initial: got %b want 0", bp_hit); end
    repeat (3) edge1();
    edge1();
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL bp_tick_suppressed: got %b want 0", cpu_en); end
    vecs++; if (state !== 2'b11) begin errs++; $display("FAIL bp_state: got %b want 11", state); end
    vecs++; if (bp_hit !== 1'b1) begin errs++; $display("FAIL bp_hit_set: got %b want 1", bp_hit); end
    edge1();
    vecs++; if (bp_hit !== 1'b1) begin errs++; $display("FAIL bp_hit_sticky: got %b want 1", bp_hit); end
    run = 1'b1;
    edge1();
    run = 1'b0;
    vecs++; if (state !== 2'b01) begin errs++; $display("FAIL bp_resume_state: got %b want 01", state); end
    vecs++; if (bp_hit !== 1'b0) begin errs++; $display("FAIL bp_hit_clear: got %b want 0", bp_hit); end
    for (int i = 1; i <= 4; i++) begin
      edge1();
      exp_en = (i == 4);
      vecs++; if (cpu_en !== exp_en) begin errs++; $display("FAIL bp_skip_pulse edge %0d: got %b want %b", i, cpu_en, exp_en); end
    end
    repeat (3) edge1();
    edge1();
    vecs++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL bp_rearm_cpu_en: got %b want 0", cpu_en); end
    vecs++; if (bp_hit !== 1'b1) begin errs++; $display("FAIL bp_rearm_hit: got %b want 1", bp_hit); end
    bp_en = 1'b0;
    run = 1'b1;
    edge1();
    run = 1'b0;
    stop = 1'b1;
    edge1();
    stop = 1'b0;
  endtask
`endif

  initial begin
    vecs = 0; errs = 0;
    exp_tcnt = 16'd0; exp_en = 1'b0;
    rst = 1'b0; run = 1'b0; stop = 1'b0; step = 1'b0;
    halt_in = 1'b0; div_load = 1'b0; div_in = 8'd0;
`ifdef CLK_STEP_BREAKPOINT_EN
    pc = 8'd0; bp_addr = 8'd0; bp_en = 1'b0;
`endif
    #2;
    test_reset();
    test_run_default();
    test_divisor();
    test_step();
    test_halt();
    test_stop_rst();
`ifdef CLK_STEP_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
